// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch-stage program-counter unit.
//   pc_state_t  : fetch FSM states (BOOT, RUN, HALT).
//   pc_sel_t    : which next-PC source won the priority decode in a cycle.
//   INST_BYTES  : sequential fetch stride.
//   DEFAULT_*   : default reset and trap vectors for 32-bit configurations.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // Next-PC source, listed from lowest to highest priority after HOLD.
  typedef enum logic [2:0] {
    SEL_HOLD     = 3'd0,
    SEL_SEQ      = 3'd1,
    SEL_RET      = 3'd2,
    SEL_CALL     = 3'd3,
    SEL_REDIRECT = 3'd4,
    SEL_TRAP     = 3'd5
  } pc_sel_t;

  localparam int unsigned INST_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: bundle between the PC unit, the branch/trap logic and the fetch port.
//   Control in : pcReady, stall, halt, trap, redirect, redirectTarget,
//                predCall, predRet, predTarget
//   Fetch out  : PC, pcValid
//   Status out : rasEmpty, rasFull
// master = the PC unit (issues fetch requests), slave = the fetch/control side.
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            pcReady;
  logic            stall;
  logic            halt;
  logic            trap;
  logic            redirect;
  logic [XLEN-1:0] redirectTarget;
  logic            predCall;
  logic            predRet;
  logic [XLEN-1:0] predTarget;

  logic [XLEN-1:0] PC;
  logic            pcValid;
  logic            rasEmpty;
  logic            rasFull;

  modport master (
    input  pcReady,
    input  stall,
    input  halt,
    input  trap,
    input  redirect,
    input  redirectTarget,
    input  predCall,
    input  predRet,
    input  predTarget,
    output PC,
    output pcValid,
    output rasEmpty,
    output rasFull
  );

  modport slave (
    output pcReady,
    output stall,
    output halt,
    output trap,
    output redirect,
    output redirectTarget,
    output predCall,
    output predRet,
    output predTarget,
    input  PC,
    input  pcValid,
    input  rasEmpty,
    input  rasFull
  );

endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
//   CLK, RES_N : clock, asynchronous active-low reset (clears the count only)
//   push       : write pushData on top; when full the oldest entry is overwritten
//   pop        : drop the top entry; ignored when empty or when push is also set
//   flush      : discard all entries; wins over push and pop
//   pushData   : address to push
//   top        : most recently pushed live entry (meaningless when empty)
//   empty/full : count == 0 / count == RAS_DEPTH
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RES_N,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] pushData,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ras_stack: RAS_DEPTH must be a power of two and at least 2");
  end

  // sp_q points at the slot the next push writes; the top lives one below it.
  // With a power-of-two depth the pointer simply wraps, so a push while full
  // lands on the oldest entry.
  logic [PtrW-1:0] sp_q, sp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic            do_push;
  logic            do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntMax);
  assign top   = mem_q[sp_q - PtrW'(1)];

  assign do_push = push && !flush;
  assign do_pop  = pop && !push && !flush && !empty;

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (flush) begin
      sp_d  = '0;
      cnt_d = '0;
    end else if (do_push) begin
      sp_d = sp_q + PtrW'(1);
      if (!full) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (do_pop) begin
      sp_d  = sp_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset: nothing reads it until it has been pushed.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[sp_q] <= pushData;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with next-PC priority select and a RAS.
//   CLK, RES_N : clock, asynchronous active-low reset
//   bus        : pc_unit_if master modport
//     in  pcReady, stall, halt       fetch handshake and pipeline control
//     in  trap, redirect(+Target)    resolved control flow from EX/WB
//     in  predCall/predRet(+Target)  predecoder hints for the current fetch
//     out PC, pcValid                fetch request
//     out rasEmpty, rasFull          return-address stack status
// Next-PC priority: trap > redirect > fire&call > fire&ret > fire > hold.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input logic       CLK,
  input logic       RES_N,
  pc_unit_if.master bus
);

  localparam logic [1:0] ST_BOOT = BOOT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_HALT = HALT;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] call_pc;
  logic            fire;
  pc_sel_t         sel;

  logic            ras_push;
  logic            ras_pop;
  logic            ras_flush;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;

  // Only bits [XLEN-1:2] of the targets matter; targets are word aligned here.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^{bus.redirectTarget[1:0], bus.predTarget[1:0]};

  assign pc_seq      = pc_q + XLEN'(INST_BYTES);
  assign redirect_pc = {bus.redirectTarget[XLEN-1:2], 2'b00};
  assign call_pc     = {bus.predTarget[XLEN-1:2], 2'b00};

  assign bus.pcValid  = (state_q == ST_RUN) && !bus.stall && !bus.halt;
  assign fire         = bus.pcValid && bus.pcReady;
  assign bus.PC       = pc_q;
  assign bus.rasEmpty = ras_empty;
  assign bus.rasFull  = ras_full;

  // Priority decode. A trap is ignored only during BOOT; trap and redirect do
  // not depend on fire, so they also override a stalled or un-accepted fetch.
  always_comb begin
    sel = SEL_HOLD;
    if (bus.trap && (state_q != ST_BOOT)) begin
      sel = SEL_TRAP;
    end else if (bus.redirect) begin
      sel = SEL_REDIRECT;
    end else if (fire && bus.predCall) begin
      // Call wins when the predecoder flags both call and return.
      sel = SEL_CALL;
    end else if (fire && bus.predRet) begin
      sel = SEL_RET;
    end else if (fire) begin
      sel = SEL_SEQ;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_flush = 1'b0;
    unique case (sel)
      SEL_TRAP: begin
        pc_d      = TRAP_VECTOR;
        ras_flush = 1'b1;
      end
      SEL_REDIRECT: begin
        pc_d = redirect_pc;
      end
      SEL_CALL: begin
        pc_d     = call_pc;
        ras_push = 1'b1;
      end
      SEL_RET: begin
        // An empty stack has no prediction; fall through sequentially.
        if (!ras_empty) begin
          pc_d    = ras_top;
          ras_pop = 1'b1;
        end else begin
          pc_d = pc_seq;
        end
      end
      SEL_SEQ: begin
        pc_d = pc_seq;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.halt && !bus.trap && !bus.redirect) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.trap || bus.redirect) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK      (CLK),
    .RES_N    (RES_N),
    .push     (ras_push),
    .pop      (ras_pop),
    .flush    (ras_flush),
    .pushData (pc_seq),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

`ifndef SYNTHESIS
  // Fetch relies on PC staying put while it back-pressures a valid request.
  property p_hold_under_backpressure;
    @(posedge CLK) disable iff (!RES_N)
      (bus.pcValid && !bus.pcReady && !bus.trap && !bus.redirect) |=> (pc_q == $past(pc_q));
  endproperty
  a_hold_under_backpressure: assert property (p_hold_under_backpressure);

  property p_flags_exclusive;
    @(posedge CLK) disable iff (!RES_N) !(ras_empty && ras_full);
  endproperty
  a_flags_exclusive: assert property (p_flags_exclusive);

  property p_halt_blocks_fetch;
    @(posedge CLK) disable iff (!RES_N) (state_q == ST_HALT) |-> !bus.pcValid;
  endproperty
  a_halt_blocks_fetch: assert property (p_halt_blocks_fetch);
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit (XLEN=32, RAS_DEPTH=4).
// The driver applies one vector per cycle just after the rising edge and queues
// the hand-computed outputs expected for that cycle; the monitor pops and
// compares on the falling edge.
module tb_pc_unit;

  logic CLK = 1'b0;
  logic RES_N = 1'b0;

  always #5 CLK = ~CLK;

  pc_unit_if #(.XLEN(32)) bus ();

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .RAS_DEPTH    (4)
  ) dut (
    .CLK   (CLK),
    .RES_N (RES_N),
    .bus   (bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        e;
    logic        f;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: compare whatever the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".pcValid"},  32'(bus.pcValid),  32'(e.v));
        check({e.name, ".PC"},       bus.PC,            e.pc);
        check({e.name, ".rasEmpty"}, 32'(bus.rasEmpty), 32'(e.e));
        check({e.name, ".rasFull"},  32'(bus.rasFull),  32'(e.f));
      end
    end
  end

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic cyc(input logic rdy, input logic stl, input logic hlt, input logic trp,
                     input logic rdr, input logic [31:0] rt, input logic cl, input logic rt_,
                     input logic [31:0] pt, input logic ev, input logic [31:0] epc,
                     input logic ee, input logic ef, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    bus.pcReady        = rdy;
    bus.stall          = stl;
    bus.halt           = hlt;
    bus.trap           = trp;
    bus.redirect       = rdr;
    bus.redirectTarget = rt;
    bus.predCall       = cl;
    bus.predRet        = rt_;
    bus.predTarget     = pt;
    e.v = ev; e.pc = epc; e.e = ee; e.f = ef; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    bus.pcReady = 1'b0; bus.stall = 1'b0; bus.halt = 1'b0; bus.trap = 1'b0;
    bus.redirect = 1'b0; bus.redirectTarget = '0; bus.predCall = 1'b0;
    bus.predRet = 1'b0; bus.predTarget = '0;

    //   rdy stl hlt trp rdr redirectTgt   cl ret predTgt      v  PC            e  f
    cyc(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     0, 32'h0,        1, 0, "reset");
    cyc(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     0, 32'h0,        1, 0, "boot");
    RES_N = 1'b1;
    // Sequential fetch after BOOT.
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h0,        1, 0, "seq0");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h4,        1, 0, "seq4");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h8,        1, 0, "seq8");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'hC,        1, 0, "seqC");
    // Back-pressure at 0x10.
    cyc(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h10,       1, 0, "wait1");
    cyc(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h10,       1, 0, "wait2");
    cyc(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h10,       1, 0, "wait3");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h10,       1, 0, "wait_fire");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h14,       1, 0, "adv14");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h18,       1, 0, "adv18");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h1C,       1, 0, "adv1C");
    // Call / return pair.
    cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h200,   1, 32'h20,       1, 0, "call");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,     1, 32'h200,      0, 0, "ret");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h24,       1, 0, "ret_pc");
    // Stall suppresses valid and holds PC.
    cyc(1, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0,     0, 32'h28,       1, 0, "stall");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h28,       1, 0, "unstall");
    // Redirect to 0 overrides the fire, then five calls overflow a 4-deep RAS.
    cyc(1, 0, 0, 0, 1, 32'h0,        0, 0, 32'h0,     1, 32'h2C,       1, 0, "redir0");
    cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h10,    1, 32'h0,        1, 0, "call_a");
    cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h20,    1, 32'h10,       0, 0, "call_b");
    cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h30,    1, 32'h20,       0, 0, "call_c");
    cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h40,    1, 32'h30,       0, 0, "call_d");
    cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h50,    1, 32'h40,       0, 1, "call_e");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,     1, 32'h50,       0, 1, "ret_a");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,     1, 32'h44,       0, 0, "ret_b");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,     1, 32'h34,       0, 0, "ret_c");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,     1, 32'h24,       0, 0, "ret_d");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,     1, 32'h14,       1, 0, "ret_e");
    // Call and return together behave as a call (pushes 0x1C).
    cyc(1, 0, 0, 0, 0, 32'h0,        1, 1, 32'h400,   1, 32'h18,       1, 0, "call_ret");
    // Trap + redirect + call in one cycle: trap wins and flushes the RAS.
    cyc(1, 0, 0, 1, 1, 32'h80,       1, 0, 32'h999,   1, 32'h400,      0, 0, "trap_same");
    cyc(1, 0, 0, 0, 1, 32'h83,       0, 0, 32'h0,     1, 32'h100,      1, 0, "trap_pc");
    cyc(1, 0, 0, 0, 1, 32'h40,       0, 1, 32'h0,     1, 32'h80,       1, 0, "redir_80");
    // HALT at 0x40 for five cycles, left by a redirect to 0x300.
    cyc(1, 0, 1, 0, 0, 32'h0,        0, 0, 32'h0,     0, 32'h40,       1, 0, "halt1");
    cyc(1, 0, 1, 0, 0, 32'h0,        0, 0, 32'h0,     0, 32'h40,       1, 0, "halt2");
    cyc(1, 0, 1, 0, 0, 32'h0,        0, 0, 32'h0,     0, 32'h40,       1, 0, "halt3");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     0, 32'h40,       1, 0, "halt4");
    cyc(1, 0, 1, 0, 0, 32'h0,        0, 0, 32'h0,     0, 32'h40,       1, 0, "halt5");
    cyc(1, 0, 0, 0, 1, 32'h300,      0, 0, 32'h0,     0, 32'h40,       1, 0, "halt_exit");
    // Back in RUN; redirect near the top of the address space to test wrap.
    cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,    1, 32'h300,      1, 0, "resume");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'hFFFF_FFFC, 1, 0, "wrap_top");
    cyc(1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h500,   1, 32'h0,        1, 0, "wrap_zero");
    cyc(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,     1, 32'h500,      0, 0, "pre_reset");

    // Asynchronous reset between edges: PC (now 0x504) and RAS must clear
    // before the next rising edge, i.e. by the falling-edge sample.
    @(posedge CLK);
    #1;
    RES_N = 1'b0;
    e.v = 1'b0; e.pc = 32'h0; e.e = 1'b1; e.f = 1'b0; e.name = "async_reset";
    sb.push_back(e);

    @(negedge CLK);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
